// File: rtl/concat_pack_pkg.sv
// concat_pack_pkg: shared sizing helpers for the concat_packer slice.
//   beats_w(ratio)     - width of a beat-count field able to hold 0..ratio.
//   out_w(in_w, ratio) - width of a packed word; consumers use it to size the
//                        nets that receive out_data, so no assignment widens
//                        or truncates.
package concat_pack_pkg;

   function automatic int unsigned beats_w(input int unsigned ratio);
      return $clog2(ratio + 1);
   endfunction

   function automatic int unsigned out_w(input int unsigned in_w, input int unsigned ratio);
      return in_w * ratio;
   endfunction

endpackage

// File: rtl/concat_packer_if.sv
// concat_packer_if: valid/ready bundle for the concat_packer.
//   in_valid / in_ready / in_data      - narrow beat stream into the packer
//   in_last                            - early word end (only when
//                                        CONCAT_PACKER_PARTIAL_EN is defined)
//   out_valid / out_ready / out_data   - packed word stream out of the packer
//   out_beats                          - number of valid beats in out_data
// Modports:
//   master - the environment: produces beats, consumes words
//   slave  - the packer itself
interface concat_packer_if
   import concat_pack_pkg::*;
#(
   parameter int unsigned IN_W  = 4,
   parameter int unsigned RATIO = 2
) ();
   localparam int unsigned OUT_W   = out_w(IN_W, RATIO);
   localparam int unsigned BEATS_W = beats_w(RATIO);

   logic               in_valid;
   logic               in_ready;
   logic [IN_W-1:0]    in_data;
`ifdef CONCAT_PACKER_PARTIAL_EN
   logic               in_last;
`endif
   logic               out_valid;
   logic               out_ready;
   logic [OUT_W-1:0]   out_data;
   logic [BEATS_W-1:0] out_beats;

   modport master (
      output in_valid,
      input  in_ready,
      output in_data,
`ifdef CONCAT_PACKER_PARTIAL_EN
      output in_last,
`endif
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_beats
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_data,
`ifdef CONCAT_PACKER_PARTIAL_EN
      input  in_last,
`endif
      output out_valid,
      input  out_ready,
      output out_data,
      output out_beats
   );

endinterface

// File: rtl/concat_pack_out_reg.sv
// concat_pack_out_reg: output holding register of the packer (valid/ready slice).
//   clk, rst      - clock, asynchronous active-high reset
//   load          - capture load_data/load_beats and raise valid
//   load_data     - packed word to hold
//   load_beats    - beat count of that word
//   ready         - downstream accepts the held word
//   valid         - a word is held
//   data, beats   - held word and its beat count; stable while valid && !ready
// The caller only asserts load when the slot is empty or being drained in the
// same cycle, so a held word is never overwritten before it is taken.
module concat_pack_out_reg #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned BEATS_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [DATA_W-1:0]  load_data,
   input  logic [BEATS_W-1:0] load_beats,
   input  logic               ready,
   output logic               valid,
   output logic [DATA_W-1:0]  data,
   output logic [BEATS_W-1:0] beats
);
   logic               valid_q;
   logic [DATA_W-1:0]  data_q;
   logic [BEATS_W-1:0] beats_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         beats_q <= '0;
      end else if (load) begin
         valid_q <= 1'b1;
         data_q  <= load_data;
         beats_q <= load_beats;
      end else if (ready) begin
         valid_q <= 1'b0;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
   assign beats = beats_q;

endmodule

// File: rtl/concat_packer.sv
// concat_packer: collects RATIO beats of IN_W bits into one IN_W*RATIO word.
// The first accepted beat lands in the MSBs, i.e. {first, second, ...}.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - concat_packer_if slave: in_valid/in_ready/in_data beat stream,
//              out_valid/out_ready/out_data/out_beats word stream
// Optional feature: define CONCAT_PACKER_PARTIAL_EN to add in_last, which
// closes a word early with zero-filled low beats and out_beats = beats taken.
// The interface instance must carry the same IN_W/RATIO as this module.
module concat_packer
   import concat_pack_pkg::*;
#(
   parameter int unsigned IN_W  = 4,
   parameter int unsigned RATIO = 2
) (
   input logic            clk,
   input logic            rst,
   concat_packer_if.slave bus
);
   localparam int unsigned OUT_W   = out_w(IN_W, RATIO);
   localparam int unsigned BEATS_W = beats_w(RATIO);
   localparam int unsigned ACC_W   = (RATIO - 1) * IN_W;
   localparam int unsigned CNT_W   = $clog2(RATIO);

   if (IN_W < 1 || RATIO < 2) begin : g_param_check
      $fatal(1, "concat_packer: need IN_W >= 1 and RATIO >= 2");
   end

   logic [CNT_W-1:0]   cnt_q;
   logic [ACC_W-1:0]   acc_q;
   logic               last;
   logic               at_end;
   logic               closing;
   logic               accept;
   logic               complete;
   logic [OUT_W-1:0]   word_full;
   logic [OUT_W-1:0]   word;
   logic [BEATS_W-1:0] word_beats;

`ifdef CONCAT_PACKER_PARTIAL_EN
   assign last = bus.in_last;
`else
   assign last = 1'b0;
`endif

   assign at_end   = (cnt_q == CNT_W'(RATIO - 1));
   assign closing  = at_end || last;
   // Only a word-closing beat needs space in the output register.
   assign bus.in_ready = !closing || !bus.out_valid || bus.out_ready;
   assign accept   = bus.in_valid && bus.in_ready;
   assign complete = accept && closing;

   // Accumulator holds earlier beats in its low bits, newest lowest.
   assign word_full = {acc_q, bus.in_data};

`ifdef CONCAT_PACKER_PARTIAL_EN
   // Left-align the cnt+1 valid beats; stale high acc bits shift out and
   // the unfilled low beats come in as zero.
   assign word       = word_full << (IN_W * (RATIO - 1 - int'(cnt_q)));
   assign word_beats = BEATS_W'(cnt_q) + BEATS_W'(1);
`else
   assign word       = word_full;
   assign word_beats = BEATS_W'(RATIO);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         acc_q <= '0;
      end else if (accept) begin
         if (closing) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            acc_q <= word_full[ACC_W-1:0];
         end
      end
   end

   concat_pack_out_reg #(
      .DATA_W  (OUT_W),
      .BEATS_W (BEATS_W)
   ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (complete),
      .load_data  (word),
      .load_beats (word_beats),
      .ready      (bus.out_ready),
      .valid      (bus.out_valid),
      .data       (bus.out_data),
      .beats      (bus.out_beats)
   );

endmodule

// File: tb/tb_concat_packer.sv
// tb_concat_packer: table-driven bench with a word scoreboard for two packers,
// RATIO=2 and RATIO=4 (IN_W=4). Expected words are queued when their beats are
// driven and popped by a monitor whenever a word handshake is about to happen.
// Build with CONCAT_PACKER_PARTIAL_EN to also exercise the in_last path.
module tb_concat_packer;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] beats;
   } exp2_t;

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  beats;
   } exp4_t;

   typedef struct {
      logic [3:0] b0;
      logic [3:0] b1;
      logic [7:0] exp;
   } vec2_t;

   typedef struct {
      logic [3:0]  b0;
      logic [3:0]  b1;
      logic [3:0]  b2;
      logic [3:0]  b3;
      logic [15:0] exp;
   } vec4_t;

   logic clk;
   logic rst;

   int total;
   int bad;
   int cyc;
   int last4_cyc;
   bit stream_chk;
   bit have_prev;

   exp2_t q2[$];
   exp4_t q4[$];
   exp2_t e2;
   exp4_t e4;

   vec2_t v2[4];
   vec4_t v4[4];

   concat_packer_if #(.IN_W(4), .RATIO(2)) if2 ();
   concat_packer_if #(.IN_W(4), .RATIO(4)) if4 ();

   concat_packer #(.IN_W(4), .RATIO(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (if2)
   );

   concat_packer #(.IN_W(4), .RATIO(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (if4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Word monitors: a valid&ready seen at the falling edge transfers at the next rise.
   always @(negedge clk) begin
      if (!rst && if2.out_valid && if2.out_ready) begin
         if (q2.size() == 0) begin
            total++;
            bad++;
            $display("FAIL r2_extra_word: got 0x%0h want no word", if2.out_data);
         end else begin
            e2 = q2.pop_front();
            check("r2_data", 32'(if2.out_data), 32'(e2.data));
            check("r2_beats", 32'(if2.out_beats), 32'(e2.beats));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && if4.out_valid && if4.out_ready) begin
         if (q4.size() == 0) begin
            total++;
            bad++;
            $display("FAIL r4_extra_word: got 0x%0h want no word", if4.out_data);
         end else begin
            e4 = q4.pop_front();
            check("r4_data", 32'(if4.out_data), 32'(e4.data));
            check("r4_beats", 32'(if4.out_beats), 32'(e4.beats));
         end
         if (stream_chk) begin
            if (have_prev) check("r4_word_gap", 32'(cyc - last4_cyc), 32'd4);
            have_prev = 1'b1;
            last4_cyc = cyc;
         end
      end
   end

   task automatic send2(input logic [3:0] d);
      bit ok;
      int t;
      ok = 1'b0;
      t = 0;
      if2.in_valid = 1'b1;
      if2.in_data  = d;
      while (!ok && t < 50) begin
         @(negedge clk);
         ok = if2.in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL send2_timeout: beat 0x%0h got in_ready=0 want accepted", d);
      end
      if2.in_valid = 1'b0;
   endtask

   task automatic send4(input logic [3:0] d, input logic last);
      bit ok;
      int t;
      ok = 1'b0;
      t = 0;
      if4.in_valid = 1'b1;
      if4.in_data  = d;
`ifdef CONCAT_PACKER_PARTIAL_EN
      if4.in_last  = last;
`else
      if (last) $display("note: in_last ignored without partial build");
`endif
      while (!ok && t < 50) begin
         @(negedge clk);
         ok = if4.in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL send4_timeout: beat 0x%0h got in_ready=0 want accepted", d);
      end
      if4.in_valid = 1'b0;
`ifdef CONCAT_PACKER_PARTIAL_EN
      if4.in_last  = 1'b0;
`endif
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q2.size() != 0 || q4.size() != 0) && t < 100) begin
         @(posedge clk);
         t++;
      end
      if (q2.size() != 0 || q4.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d/%0d words pending want 0/0", q2.size(), q4.size());
         q2.delete();
         q4.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad = 0;
      stream_chk = 1'b0;
      have_prev = 1'b0;
      last4_cyc = 0;

      v2[0] = '{b0: 4'hA, b1: 4'h5, exp: 8'hA5};
      v2[1] = '{b0: 4'hF, b1: 4'h0, exp: 8'hF0};
      v2[2] = '{b0: 4'h1, b1: 4'hE, exp: 8'h1E};
      v2[3] = '{b0: 4'h0, b1: 4'h0, exp: 8'h00};

      v4[0] = '{b0: 4'h1, b1: 4'h2, b2: 4'h3, b3: 4'h4, exp: 16'h1234};
      v4[1] = '{b0: 4'h5, b1: 4'h6, b2: 4'h7, b3: 4'h8, exp: 16'h5678};
      v4[2] = '{b0: 4'hF, b1: 4'hE, b2: 4'hD, b3: 4'hC, exp: 16'hFEDC};
      v4[3] = '{b0: 4'h0, b1: 4'h9, b2: 4'h0, b3: 4'h9, exp: 16'h0909};

      rst = 1'b1;
      if2.in_valid  = 1'b0;
      if2.in_data   = '0;
      if2.out_ready = 1'b1;
      if4.in_valid  = 1'b0;
      if4.in_data   = '0;
      if4.out_ready = 1'b1;
`ifdef CONCAT_PACKER_PARTIAL_EN
      if2.in_last   = 1'b0;
      if4.in_last   = 1'b0;
`endif

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_r2_out_valid", 32'(if2.out_valid), 32'd0);
      check("rst_r2_in_ready", 32'(if2.in_ready), 32'd1);
      check("rst_r2_out_data", 32'(if2.out_data), 32'd0);
      check("rst_r2_out_beats", 32'(if2.out_beats), 32'd0);
      check("rst_r4_out_valid", 32'(if4.out_valid), 32'd0);
      check("rst_r4_in_ready", 32'(if4.in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // RATIO=2 vectors, first one also checks one-cycle latency
      for (int i = 0; i < 4; i++) begin
         q2.push_back(exp2_t'{data: v2[i].exp, beats: 2'd2});
         send2(v2[i].b0);
         send2(v2[i].b1);
         if (i == 0) begin
            check("r2_latency_valid", 32'(if2.out_valid), 32'd1);
            check("r2_latency_data", 32'(if2.out_data), 32'h0000_00A5);
         end
      end
      drain();

      // RATIO=4 back-to-back stream: one word every 4 cycles
      stream_chk = 1'b1;
      have_prev  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         q4.push_back(exp4_t'{data: v4[i].exp, beats: 3'd4});
         send4(v4[i].b0, 1'b0);
         send4(v4[i].b1, 1'b0);
         send4(v4[i].b2, 1'b0);
         send4(v4[i].b3, 1'b0);
      end
      drain();
      stream_chk = 1'b0;

      // Backpressure with completing beat accepted in the drain cycle
      if2.out_ready = 1'b0;
      q2.push_back(exp2_t'{data: 8'hA5, beats: 2'd2});
      q2.push_back(exp2_t'{data: 8'h3C, beats: 2'd2});
      send2(4'hA);
      send2(4'h5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(if2.out_valid), 32'd1);
         check("bp_hold_data", 32'(if2.out_data), 32'h0000_00A5);
         check("bp_hold_beats", 32'(if2.out_beats), 32'd2);
      end
      @(posedge clk);
      #1;
      send2(4'h3);
      if2.in_valid = 1'b1;
      if2.in_data  = 4'hC;
      repeat (2) begin
         @(negedge clk);
         check("bp_stall_in_ready", 32'(if2.in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      if2.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", 32'(if2.in_ready), 32'd1);
      @(posedge clk);
      #1;
      if2.in_valid = 1'b0;
      check("bp_no_gap_valid", 32'(if2.out_valid), 32'd1);
      check("bp_no_gap_data", 32'(if2.out_data), 32'h0000_003C);
      drain();

      // Reset mid-word discards the pending beat
      send2(4'h7);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", 32'(if2.out_valid), 32'd0);
      check("midrst_out_data", 32'(if2.out_data), 32'd0);
      check("midrst_in_ready", 32'(if2.in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q2.push_back(exp2_t'{data: 8'h12, beats: 2'd2});
      send2(4'h1);
      send2(4'h2);
      drain();

`ifdef CONCAT_PACKER_PARTIAL_EN
      // Early word end, then a full word starting from beat 0
      q4.push_back(exp4_t'{data: 16'h9800, beats: 3'd2});
      send4(4'h9, 1'b0);
      send4(4'h8, 1'b1);
      q4.push_back(exp4_t'{data: 16'h1234, beats: 3'd4});
      send4(4'h1, 1'b0);
      send4(4'h2, 1'b0);
      send4(4'h3, 1'b0);
      send4(4'h4, 1'b0);
      q4.push_back(exp4_t'{data: 16'hA000, beats: 3'd1});
      send4(4'hA, 1'b1);
      drain();
`endif

      repeat (3) @(posedge clk);
      #1;
      check("final_r2_idle", 32'(if2.out_valid), 32'd0);
      check("final_r4_idle", 32'(if4.out_valid), 32'd0);
      check("final_queues_empty", 32'(q2.size() + q4.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/concat_packer.md
# concat_packer

Sequential width packer that collects `RATIO` narrow input beats and emits one concatenated word of `IN_W*RATIO` bits. The first accepted beat lands in the MSBs, matching `{first, second, ...}` concatenation order. It sits directly upstream of the concatenation consumers checked by the width-mismatch rules: it produces exactly-sized concatenated words, so downstream assignments never widen or truncate. Valid/ready handshake on both sides.

## Interface
- `IN_W`, default 4: input beat width, ≥1.
- `RATIO`, default 2: beats per output word, ≥2.
- `OUT_W`, localparam: `IN_W*RATIO`. Not overridable.
- `clk`, input, 1: single clock. All state is on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: packer can accept a beat.
- `in_data`, input, `IN_W`: beat payload.
- `in_last`, input, 1: ends the word early. Present only with `CONCAT_PACKER_PARTIAL_EN`.
- `out_valid`, output, 1: `out_data` holds a complete word.
- `out_ready`, input, 1: downstream accepts the word.
- `out_data`, output, `OUT_W`: packed word.
- `out_beats`, output, `$clog2(RATIO+1)`: number of valid beats in the word, always `RATIO` without the macro.

## Operation
- State:
  - beat counter `cnt`, 0..RATIO-1;
  - accumulator `acc` of `(RATIO-1)*IN_W` bits;
  - output register (`out_data`, `out_beats`, `out_valid`).
- Accept rule: a beat is accepted when `in_valid && in_ready`.
- Beat k (0-based) is placed at `out_data[OUT_W-1-k*IN_W -: IN_W]`.
- Accepted beat with `cnt < RATIO-1`:
  - shift the beat into `acc`;
  - `cnt++`.
- Accepted beat with `cnt == RATIO-1` (the completing beat):
  - output register loads `{acc, in_data}`;
  - `out_beats = RATIO`;
  - `out_valid = 1`;
  - `cnt = 0`.
- `in_ready = (cnt != RATIO-1) || !out_valid || out_ready`. Filling beats are never stalled; only the completing beat waits for output space.
- `out_valid` clears on `out_valid && out_ready` unless a completing beat is accepted in the same cycle, in which case the new word is loaded.
- `out_data` and `out_beats` are stable while `out_valid && !out_ready`.
- Reset value of all outputs and state is 0; `in_ready` is 1 out of reset.
- Reset mid-word discards the accumulated beats and any held output word. No partial word is emitted.

## Timing
- Latency: `out_valid` rises one cycle after the completing beat is accepted.
- Throughput: one beat per cycle sustained when `out_ready` = 1. Back-to-back words are emitted every `RATIO` cycles.
- No combinational path from `in_valid` or `in_data` to any output.
- `in_ready` depends combinationally on `out_ready` only.
- Asynchronous reset assertion clears state immediately; deassertion is expected to be synchronous to `clk` (handled outside the block).

## Configuration
- `CONCAT_PACKER_PARTIAL_EN` defined:
  - `in_last` port exists.
  - An accepted beat with `in_last` = 1 is treated as completing regardless of `cnt`.
  - Unfilled low beats are zero.
  - `out_beats = cnt+1`.
  - `in_ready` uses `(cnt != RATIO-1 && !in_last)` in place of `(cnt != RATIO-1)`.
- Not defined:
  - no `in_last` port;
  - words complete only at `RATIO` beats;
  - `out_beats` is tied to `RATIO`.

## Structure
- Package `concat_pack_pkg`:
  - function `beats_w(ratio)` returning `$clog2(ratio+1)`;
  - function `out_w(in_w, ratio)` used for the localparam and by consumers sizing their destination nets.
- Sub-module `concat_pack_out_reg`: the output holding register (valid/ready slice with load/hold/clear). Instantiated once.
- Elaboration check: `IN_W ≥ 1` and `RATIO ≥ 2`, otherwise `$fatal`.

## Test plan
- `IN_W`=4, `RATIO`=2, `out_ready`=1; beats 0xA, 0x5 → next cycle `out_valid`=1, `out_data`=0xA5, `out_beats`=2.
- `IN_W`=4, `RATIO`=4; beats 0x1, 0x2, 0x3, 0x4 → `out_data`=0x1234, then a stream of 8 beats gives 0x1234, 0x5678 on consecutive 4-cycle boundaries.
- Backpressure, `RATIO`=2: word 0xA5 held with `out_ready`=0; beat 0x3 is accepted; beat 0xC sees `in_ready`=0 until `out_ready`=1; that same cycle 0xC is accepted and `out_data` becomes 0x3C next cycle with no gap.
- Reset mid-word: after beat 0x7 (`cnt`=1), assert `rst` for 1 cycle → `out_valid`=0, `cnt`=0; beats 0x1, 0x2 → 0x12, with no trace of 0x7.
- Partial (macro on, `RATIO`=4): beats 0x9, 0x8 with `in_last` on the second → `out_data`=0x9800, `out_beats`=2; the next word starts at `cnt`=0.
- Simultaneous events: `out_ready`=1 in the same cycle a completing beat is accepted → `out_valid` stays 1 and the new word replaces the old one exactly once (scoreboard shows no drop or duplicate).
